// File: rtl/hs32_pkg.sv
// +----------------------------------------------------------------------+
// | hs32_pkg: fetch-unit state encoding and default reset vector          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package hs32_pkg;

   localparam logic [31:0] HS32_RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/hs32_fifo2.sv
// +----------------------------------------------------------------------+
// | hs32_fifo2: 2-entry 32-bit prefetch FIFO, head entry drives dout      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module hs32_fifo2 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        valid,
   output logic [1:0]  count
);

   logic [31:0] e0_q, e0_d;
   logic [31:0] e1_q, e1_d;
   logic [1:0]  count_q, count_d;
   logic        do_pop;
   logic        do_push;

   always_comb begin
      e0_d    = e0_q;
      e1_d    = e1_q;
      count_d = count_q;
      do_pop  = pop && (count_q != 2'd0);
      do_push = push && ((count_q != 2'd2) || do_pop);
      if (clear) begin
         count_d = 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b11: begin
               // Simultaneous push/pop keeps occupancy; the new word queues behind any survivor.
               if (count_q == 2'd1) begin
                  e0_d = din;
               end else begin
                  e0_d = e1_q;
                  e1_d = din;
               end
            end
            2'b01: begin
               e0_d    = e1_q;
               count_d = count_q - 2'd1;
            end
            2'b10: begin
               if (count_q == 2'd0) e0_d = din;
               else                 e1_d = din;
               count_d = count_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e0_q    <= 32'h0;
         e1_q    <= 32'h0;
         count_q <= 2'd0;
      end else begin
         e0_q    <= e0_d;
         e1_q    <= e1_d;
         count_q <= count_d;
      end
   end

   assign dout  = e0_q;
   assign valid = (count_q != 2'd0);
   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/hs32_fetch.sv
// +----------------------------------------------------------------------+
// | hs32_fetch: instruction fetch with one outstanding request, 2-deep     |
// | prefetch buffer and branch redirect. Revision: 1.0                    |
// +----------------------------------------------------------------------+
`default_nettype none

module hs32_fetch
   import hs32_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = HS32_RESET_VECTOR
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] mem_addr,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [31:0] mem_data,
   output logic [31:0] instd,
   output logic        ackd,
   input  logic        reqd,
   input  logic        flush,
   input  logic [31:0] newpc
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  mem_addr_q, mem_addr_d;
   logic         mem_req_q, mem_req_d;
   logic         started_q, started_d;

   logic [31:0]  pc_flush;
   logic [31:0]  pc_inc;
   logic         fifo_push;
   logic         fifo_pop;
   logic         fifo_valid;
   logic [1:0]   fifo_count;
   logic [1:0]   count_after;

   assign pc_flush    = {newpc[31:2], 2'b00};
   assign pc_inc      = pc_q + 32'd4;
   assign fifo_pop    = reqd && fifo_valid && !flush;
   assign fifo_push   = (state_q == ST_REQ) && mem_ack && !flush;
   assign count_after = fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mem_addr_d = mem_addr_q;
      mem_req_d  = mem_req_q;
      // Holds off the first request by one cycle after reset release.
      started_d  = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (flush) begin
               pc_d       = pc_flush;
               state_d    = ST_REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = pc_flush;
            end else if (started_q && (fifo_count < 2'd2)) begin
               state_d    = ST_REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = pc_q;
            end
         end
         ST_REQ: begin
            if (mem_ack) begin
               if (flush) begin
                  pc_d       = pc_flush;
                  mem_addr_d = pc_flush;
               end else begin
                  pc_d = pc_inc;
                  if (count_after < 2'd2) begin
                     mem_addr_d = pc_inc;
                  end else begin
                     state_d   = ST_IDLE;
                     mem_req_d = 1'b0;
                  end
               end
            end else if (flush) begin
               // The in-flight word must still be drained before redirecting.
               pc_d    = pc_flush;
               state_d = ST_DROP;
            end
         end
         ST_DROP: begin
            if (flush) pc_d = pc_flush;
            if (mem_ack) begin
               state_d    = ST_REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = flush ? pc_flush : pc_q;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_VECTOR;
         mem_addr_q <= RESET_VECTOR;
         mem_req_q  <= 1'b0;
         started_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= mem_req_d;
         started_q  <= started_d;
      end
   end

   hs32_fifo2 u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (flush),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .din     (mem_data),
      .dout    (instd),
      .valid   (fifo_valid),
      .count   (fifo_count)
   );

   assign mem_addr = mem_addr_q;
   assign mem_req  = mem_req_q;
   assign ackd     = fifo_valid;

endmodule

`default_nettype wire
